pipe_ctrl: RTL and testbench

- Parametrised pipeline control unit for the RISC-V core; successor to the single-stage jump/hold controller.
- Merges N external hold requests, each with its own stage depth, into per-stage hold flags.
- A jump that arrives while the pipe is held is deferred and issued when the hold releases.
- Generates a multi-cycle flush of FLUSH_CYCLES bubbles after every issued jump. Sits between ex, the bus/interrupt hold sources, and the pc/if_id/id_ex registers.

---
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges hold sources into per-stage stalls, defers jumps under hold,
// and flushes FLUSH_CYCLES bubbles per issued jump. Define PIPE_CTRL_STAT_EN for stall/flush counters.
//
// state | meaning
// IDLE  | no jump in flight
// PEND  | jump received under hold, waiting for release
// FLUSH | bubbles still owed for the last issued jump
module pipe_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int NUM_STAGES   = 3,
  parameter int NUM_HOLD_SRC = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int LVL_W        = $clog2(NUM_STAGES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             jump_addr_i,
  input  logic                          jump_en_i,
  input  logic [NUM_HOLD_SRC-1:0]       hold_req_i,
  input  logic [NUM_HOLD_SRC*LVL_W-1:0] hold_lvl_i,
  output logic [ADDR_W-1:0]             jump_addr_o,
  output logic                          jump_en_o,
  output logic [NUM_STAGES-1:0]         hold_o,
  output logic [NUM_STAGES-1:0]         flush_o,
`ifdef PIPE_CTRL_STAT_EN
  output logic [31:0]                   stall_cnt_o,
  output logic [31:0]                   flush_cnt_o,
`endif
  output logic                          busy_o
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pend_addr, pend_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ADDR_W-1:0]   addr_sel;
  logic [NUM_STAGES-1:0] hold_vec;
  logic [LVL_W-1:0]    lvl;
  logic                hold_any;
  logic                issue;
  logic                flush_st;

  assign hold_any = |hold_req_i;

  // Out-of-range levels clamp to the deepest stage, giving a thermometer from bit 0.
  always_comb begin
    hold_vec = '0;
    lvl      = '0;
    for (int i = 0; i < NUM_HOLD_SRC; i++) begin
      lvl = hold_lvl_i[i*LVL_W +: LVL_W];
      if (int'(lvl) >= NUM_STAGES) lvl = LVL_W'(NUM_STAGES - 1);
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (hold_req_i[i] && int'(lvl) >= k) hold_vec[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_addr;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    flush_st  = 1'b0;
    addr_sel  = jump_addr_i;
    case (state)
      IDLE: begin
        if (jump_en_i) begin
          if (hold_any) begin
            pend_nxt  = jump_addr_i;
            state_nxt = PEND;
          end else begin
            issue = 1'b1;
          end
        end
      end
      PEND: begin
        if (hold_any) begin
          if (jump_en_i) pend_nxt = jump_addr_i;
        end else begin
          issue    = 1'b1;
          addr_sel = jump_en_i ? jump_addr_i : pend_addr;
        end
      end
      FLUSH: begin
        flush_st = 1'b1;
        if (hold_any) begin
          if (jump_en_i) begin
            pend_nxt  = jump_addr_i;
            state_nxt = PEND;
          end
        end else if (jump_en_i) begin
          issue = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (issue) begin
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend_addr <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      pend_addr <= pend_nxt;
      cnt       <= cnt_nxt;
    end
  end

  assign jump_en_o   = issue && !rst;
  assign jump_addr_o = (issue && !rst) ? addr_sel : '0;
  assign flush_o     = (!rst && (issue || flush_st)) ? {{(NUM_STAGES-1){1'b1}}, 1'b0} : '0;
  assign hold_o      = rst ? '0 : hold_vec;
  assign busy_o      = !rst && (state != IDLE);

`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hold_any && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      if (issue && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt_o = rst ? '0 : stall_q;
  assign flush_cnt_o = rst ? '0 : flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl with default parameters (3 stages, 2 hold sources, 2 flush cycles).
module tb_pipe_ctrl;

  typedef struct packed {
    logic        r;
    logic        en;
    logic [31:0] a;
    logic [1:0]  req;
    logic [3:0]  lvl;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] jump_addr = '0;
  logic        jump_en = 1'b0;
  logic [1:0]  hold_req = '0;
  logic [3:0]  hold_lvl = '0;
  logic [31:0] jump_addr_o;
  logic        jump_en_o;
  logic [2:0]  hold_o;
  logic [2:0]  flush_o;
  logic        busy_o;
`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [39:0] obs;
  assign obs = {jump_en_o, jump_addr_o, flush_o, hold_o, busy_o};

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .jump_addr_i (jump_addr),
    .jump_en_i   (jump_en),
    .hold_req_i  (hold_req),
    .hold_lvl_i  (hold_lvl),
    .jump_addr_o (jump_addr_o),
    .jump_en_o   (jump_en_o),
    .hold_o      (hold_o),
    .flush_o     (flush_o),
`ifdef PIPE_CTRL_STAT_EN
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o),
`endif
    .busy_o      (busy_o)
  );

  function automatic stim_t st(input logic r, input logic en, input logic [31:0] a,
                               input logic [1:0] req, input logic [3:0] lvl);
    return {r, en, a, req, lvl};
  endfunction

  // Expected {jump_en_o, jump_addr_o, flush_o, hold_o, busy_o}
  function automatic logic [39:0] ex(input logic en, input logic [31:0] a,
                                     input logic [2:0] fl, input logic [2:0] hd, input logic bz);
    return {en, a, fl, hd, bz};
  endfunction

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic apply(input stim_t v);
    @(negedge clk);
    rst       = v.r;
    jump_en   = v.en;
    jump_addr = v.a;
    hold_req  = v.req;
    hold_lvl  = v.lvl;
    #1;
  endtask

  task automatic test_reset();
    stim_t s[$];
    logic [39:0] e[$];
    s.push_back(st(1, 1, 32'hAAAA_0000, 2'b11, 4'b1010)); e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    s.push_back(st(1, 1, 32'hAAAA_0000, 2'b11, 4'b1010)); e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0000));         e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL reset[%0d] got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_plain_jump();
    stim_t s[$];
    logic [39:0] e[$];
    s.push_back(st(0, 1, 32'h100, 2'b00, 4'b0)); e.push_back(ex(1, 32'h100, 3'b110, 3'b000, 0));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b110, 3'b000, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL plain_jump[%0d] got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_deferred();
    stim_t s[$];
    logic [39:0] e[$];
    s.push_back(st(0, 1, 32'h200, 2'b01, 4'b0010));   e.push_back(ex(0, 0, 3'b000, 3'b111, 0));
    s.push_back(st(0, 1, 32'h200, 2'b01, 4'b0010));   e.push_back(ex(0, 0, 3'b000, 3'b111, 1));
    s.push_back(st(0, 1, 32'h200, 2'b01, 4'b0010));   e.push_back(ex(0, 0, 3'b000, 3'b111, 1));
    s.push_back(st(0, 0, 32'hDEAD, 2'b00, 4'b0010));  e.push_back(ex(1, 32'h200, 3'b110, 3'b000, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));        e.push_back(ex(0, 0, 3'b110, 3'b000, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));        e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL deferred[%0d] got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_hold_merge();
    stim_t s[$];
    logic [39:0] e[$];
    s.push_back(st(0, 0, 0, 2'b11, 4'b0100)); e.push_back(ex(0, 0, 3'b000, 3'b011, 0));
    s.push_back(st(0, 0, 0, 2'b10, 4'b0100)); e.push_back(ex(0, 0, 3'b000, 3'b011, 0));
    s.push_back(st(0, 0, 0, 2'b01, 4'b0100)); e.push_back(ex(0, 0, 3'b000, 3'b001, 0));
    // level 3 is past the last stage and clamps to the full thermometer
    s.push_back(st(0, 0, 0, 2'b01, 4'b0111)); e.push_back(ex(0, 0, 3'b000, 3'b111, 0));
    s.push_back(st(0, 0, 0, 2'b10, 4'b1000)); e.push_back(ex(0, 0, 3'b000, 3'b111, 0));
    s.push_back(st(0, 0, 0, 2'b00, 4'b1111)); e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL hold_merge[%0d] got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_pend_latest();
    stim_t s[$];
    logic [39:0] e[$];
    s.push_back(st(0, 1, 32'h210, 2'b10, 4'b0000)); e.push_back(ex(0, 0, 3'b000, 3'b001, 0));
    s.push_back(st(0, 1, 32'h220, 2'b10, 4'b0000)); e.push_back(ex(0, 0, 3'b000, 3'b001, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0000));   e.push_back(ex(1, 32'h220, 3'b110, 3'b000, 1));
    s.push_back(st(0, 1, 32'h230, 2'b00, 4'b0000)); e.push_back(ex(1, 32'h230, 3'b110, 3'b000, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0000));   e.push_back(ex(0, 0, 3'b110, 3'b000, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0000));   e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL pend_latest[%0d] got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_hold_in_flush();
    stim_t s[$];
    logic [39:0] e[$];
    s.push_back(st(0, 1, 32'h300, 2'b00, 4'b0)); e.push_back(ex(1, 32'h300, 3'b110, 3'b000, 0));
    for (int k = 0; k < 4; k++) begin
      s.push_back(st(0, 0, 32'h0, 2'b01, 4'b0)); e.push_back(ex(0, 0, 3'b110, 3'b001, 1));
    end
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b110, 3'b000, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL hold_in_flush[%0d] got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_flush_to_pend();
    stim_t s[$];
    logic [39:0] e[$];
    s.push_back(st(0, 1, 32'h700, 2'b00, 4'b0)); e.push_back(ex(1, 32'h700, 3'b110, 3'b000, 0));
    s.push_back(st(0, 1, 32'h710, 2'b01, 4'b0)); e.push_back(ex(0, 0, 3'b110, 3'b001, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(1, 32'h710, 3'b110, 3'b000, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b110, 3'b000, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL flush_to_pend[%0d] got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    logic [39:0] e[$];
    s.push_back(st(0, 1, 32'h600, 2'b00, 4'b0)); e.push_back(ex(1, 32'h600, 3'b110, 3'b000, 0));
    s.push_back(st(1, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    s.push_back(st(0, 1, 32'h610, 2'b01, 4'b0)); e.push_back(ex(0, 0, 3'b000, 3'b001, 0));
    s.push_back(st(1, 1, 32'h610, 2'b01, 4'b0)); e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL reset_mid[%0d] got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    logic [39:0] e[$];
    s.push_back(st(1, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    s.push_back(st(0, 1, 32'h400, 2'b00, 4'b0)); e.push_back(ex(1, 32'h400, 3'b110, 3'b000, 0));
    s.push_back(st(0, 1, 32'h500, 2'b00, 4'b0)); e.push_back(ex(1, 32'h500, 3'b110, 3'b000, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b110, 3'b000, 1));
    s.push_back(st(0, 0, 32'h0, 2'b00, 4'b0));   e.push_back(ex(0, 0, 3'b000, 3'b000, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %h expected %h", i, obs, e[i]);
      end
    end
`ifdef PIPE_CTRL_STAT_EN
    checks++;
    if (flush_cnt_o !== 32'd2) begin
      errors++;
      $display("FAIL flush_cnt got %0d expected 2", flush_cnt_o);
    end
    checks++;
    if (stall_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL stall_cnt got %0d expected 0", stall_cnt_o);
    end
    apply(st(0, 0, 32'h0, 2'b10, 4'b0));
    apply(st(0, 0, 32'h0, 2'b00, 4'b0));
    checks++;
    if (stall_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL stall_cnt_after_hold got %0d expected 1", stall_cnt_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_plain_jump();
    test_deferred();
    test_hold_merge();
    test_pend_latest();
    test_hold_in_flush();
    test_flush_to_pend();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
